// File: rtl/compute_core_host_seq.sv
// compute_core_host_seq: host-side sequencer that loads core BRAM, issues one
// instruction, waits for completion and streams a result block back out.
module compute_core_host_seq #(
  parameter int DW = 64,
  parameter int AW = 10,
  parameter int TIMEOUT_CYC = 1048576,
  parameter int DELAY_BRAM = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          job_valid,
  output logic          job_ready,
  input  logic [4:0]    job_ins,
  input  logic [9:0]    job_op1,
  input  logic [9:0]    job_op2,
  input  logic [9:0]    job_op3,
  input  logic [9:0]    job_ld_base,
  input  logic [10:0]   job_ld_cnt,
  input  logic [9:0]    job_rd_base,
  input  logic [10:0]   job_rd_cnt,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [AW-1:0] address_ext,
  output logic [DW-1:0] dina_ext,
  output logic          wea_ext,
  output logic [34:0]   command_in,
  output logic          command_we0,
  output logic          command_we1,
  input  logic [DW-1:0] doutb_ext,
  input  logic          done_ins_computation,
  output logic          busy,
  output logic          job_done,
  output logic          timeout_err
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [2:0] {IDLE, CFG_LD, LOAD, CMD, WAIT, CFG_RD, READ, DONE} state_t;
  state_t state_q, state_d;
  logic [4:0] ins_q;
  logic [9:0] op1_q, op2_q, op3_q, ld_base_q, rd_base_q;
  logic [10:0] ld_cnt_q, rd_cnt_q, i_q, i_d, j_q, j_d;
  logic [TW-1:0] wcnt_q, wcnt_d;
  logic terr_q, terr_d;
  logic [DW-1:0] mem_q [2];
  logic wp_q, rp_q, pend_q;
  logic [1:0] fcnt_q;
  logic accept, issue, push, pop;
  assign accept = job_valid & job_ready;
  assign pop = m_valid & m_ready;
  assign push = pend_q & (DELAY_BRAM == 1);
  // a word leaving this cycle frees its slot, which keeps reads at one per cycle
  assign issue = (state_q == READ) && (j_q != rd_cnt_q) &&
                 ({1'b0, fcnt_q} + {2'b0, pend_q} - {2'b0, pop} < 3'd2);
  always_comb begin
    state_d = state_q;
    i_d = i_q;
    j_d = j_q;
    wcnt_d = wcnt_q;
    terr_d = terr_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = CFG_LD;
        i_d = '0;
        j_d = '0;
        wcnt_d = '0;
        terr_d = 1'b0;
      end
      CFG_LD: state_d = (ld_cnt_q == 11'd0) ? CMD : LOAD;
      LOAD: if (s_valid) begin
        i_d = i_q + 11'd1;
        if (i_d == ld_cnt_q) state_d = CMD;
      end
      CMD: state_d = WAIT;
      // the first WAIT cycle ignores done, which may be stale from an earlier job
      WAIT: if (wcnt_q != '0 && done_ins_computation) state_d = CFG_RD;
      else begin
        wcnt_d = wcnt_q + 1'b1;
        if (wcnt_d == TW'(TIMEOUT_CYC)) begin
          terr_d = 1'b1;
          state_d = CFG_RD;
        end
      end
      CFG_RD: state_d = (terr_q || rd_cnt_q == 11'd0) ? DONE : READ;
      READ: begin
        j_d = j_q + 11'(issue);
        if (j_q == rd_cnt_q && !pend_q && fcnt_q == 2'd0) state_d = DONE;
      end
      DONE: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      {ins_q, op1_q, op2_q, op3_q, ld_base_q, rd_base_q} <= '0;
      {ld_cnt_q, rd_cnt_q, i_q, j_q} <= '0;
      wcnt_q <= '0;
      terr_q <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      {wp_q, rp_q, pend_q} <= '0;
      fcnt_q <= '0;
    end else begin
      state_q <= state_d;
      i_q <= i_d;
      j_q <= j_d;
      wcnt_q <= wcnt_d;
      terr_q <= terr_d;
      pend_q <= issue;
      if (accept) begin
        ins_q <= job_ins;
        op1_q <= job_op1;
        op2_q <= job_op2;
        op3_q <= job_op3;
        ld_base_q <= job_ld_base;
        rd_base_q <= job_rd_base;
        ld_cnt_q <= (job_ld_cnt > 11'd1024) ? 11'd1024 : job_ld_cnt;
        rd_cnt_q <= (job_rd_cnt > 11'd1024) ? 11'd1024 : job_rd_cnt;
      end
      if (push) begin
        mem_q[wp_q] <= doutb_ext;
        wp_q <= ~wp_q;
      end
      if (pop) rp_q <= ~rp_q;
      fcnt_q <= fcnt_q + 2'(push) - 2'(pop);
    end
  end
  assign job_ready = (state_q == IDLE) & rst;
  assign s_ready = state_q == LOAD;
  assign wea_ext = s_ready & s_valid;
  assign dina_ext = wea_ext ? s_data : '0;
  assign address_ext = (state_q == LOAD) ? AW'(i_q[9:0]) : (state_q == READ) ? AW'(j_q[9:0]) : '0;
  assign command_we0 = state_q inside {CFG_LD, CMD, CFG_RD};
  assign command_in = (state_q == CMD) ? {op3_q, op2_q, op1_q, ins_q} :
                      command_we0 ? {ld_base_q, 10'd0, rd_base_q, 5'd0} : '0;
  assign command_we1 = 1'b0;
  assign m_valid = fcnt_q != 2'd0;
  assign m_data = mem_q[rp_q];
  assign busy = state_q != IDLE;
  assign job_done = state_q == DONE;
  assign timeout_err = terr_q;
endmodule

// File: tb/tb_compute_core_host_seq.sv
// tb_compute_core_host_seq: directed checks of the host sequencer against a
// small core model (1-cycle BRAM read, done 5 cycles after an instruction).
module tb_compute_core_host_seq;
  logic clk = 0, rst = 0;
  logic job_valid = 0, job_ready;
  logic [4:0] job_ins = 0;
  logic [9:0] job_op1 = 0, job_op2 = 0, job_op3 = 0, job_ld_base = 0, job_rd_base = 0;
  logic [10:0] job_ld_cnt = 0, job_rd_cnt = 0;
  logic [63:0] s_data = 0, m_data, dina_ext, doutb_ext = 0;
  logic s_valid = 0, s_ready, m_valid, m_ready = 1;
  logic [9:0] address_ext;
  logic wea_ext, command_we0, command_we1, done_ins_computation, busy, job_done, timeout_err;
  logic [34:0] command_in;
  logic force_done = 0, auto_done = 1, dhi = 0, armed = 0;
  int dcnt = 0;
  int checks = 0, errors = 0;
  logic [9:0] wa_q[$];
  logic [63:0] wd_q[$];
  logic [34:0] cmd_q[$];
  logic [63:0] md_q[$];
  int done_cnt = 0, mv_cnt = 0, busy_cnt = 0, stall_viol = 0;
  logic prev_stall = 0;
  logic [63:0] prev_data = 0;

  compute_core_host_seq #(.DW(64), .AW(10), .TIMEOUT_CYC(16), .DELAY_BRAM(1)) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready), .job_ins(job_ins),
    .job_op1(job_op1), .job_op2(job_op2), .job_op3(job_op3), .job_ld_base(job_ld_base),
    .job_ld_cnt(job_ld_cnt), .job_rd_base(job_rd_base), .job_rd_cnt(job_rd_cnt),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .address_ext(address_ext), .dina_ext(dina_ext),
    .wea_ext(wea_ext), .command_in(command_in), .command_we0(command_we0),
    .command_we1(command_we1), .doutb_ext(doutb_ext),
    .done_ins_computation(done_ins_computation), .busy(busy), .job_done(job_done),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  assign done_ins_computation = force_done | dhi;
  always @(posedge clk) doutb_ext <= 64'hD0000 + 64'(address_ext);
  always @(posedge clk) begin
    if (command_we0 && command_in[4:0] != 5'd0) begin
      dcnt <= 5;
      armed <= 1;
    end else if (command_we0) begin
      armed <= 0;
      dhi <= 0;
    end else if (armed && dcnt > 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1 && auto_done) dhi <= 1;
    end
  end

  always @(negedge clk) begin
    if (wea_ext) begin
      wa_q.push_back(address_ext);
      wd_q.push_back(dina_ext);
    end
    if (command_we0) cmd_q.push_back(command_in);
    if (m_valid && m_ready) md_q.push_back(m_data);
    if (m_valid) mv_cnt++;
    if (job_done) done_cnt++;
    if (busy) busy_cnt++;
    if (prev_stall && m_data !== prev_data) stall_viol++;
    prev_stall = m_valid & ~m_ready;
    prev_data = m_data;
  end

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    cmd_q.delete();
    md_q.delete();
    done_cnt = 0;
    mv_cnt = 0;
    busy_cnt = 0;
    stall_viol = 0;
  endtask

  task automatic start_job(input logic [4:0] ins, input logic [9:0] o1, input logic [9:0] o2,
                           input logic [9:0] o3, input logic [9:0] lb, input logic [10:0] lc,
                           input logic [9:0] rb, input logic [10:0] rc);
    clear_log();
    job_ins = ins; job_op1 = o1; job_op2 = o2; job_op3 = o3;
    job_ld_base = lb; job_ld_cnt = lc; job_rd_base = rb; job_rd_cnt = rc;
    job_valid = 1;
    @(posedge clk); #1;
    job_valid = 0;
  endtask

  task automatic run_job(input logic [4:0] ins, input logic [9:0] o1, input logic [9:0] o2,
                         input logic [9:0] o3, input logic [9:0] lb, input logic [10:0] lc,
                         input logic [9:0] rb, input logic [10:0] rc, input bit rnd);
    int k, guard;
    logic hs, fin;
    start_job(ins, o1, o2, o3, lb, lc, rb, rc);
    k = 0;
    guard = 0;
    while (k < int'(lc) && guard < 5000) begin
      s_valid = 1;
      s_data = 64'(k + 1);
      @(negedge clk);
      hs = s_ready;
      @(posedge clk); #1;
      if (hs) k++;
      guard++;
    end
    s_valid = 0;
    fin = 0;
    guard = 0;
    while (!fin && guard < 20000) begin
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      fin = job_done;
      @(posedge clk); #1;
      guard++;
    end
    m_ready = 1;
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL job_done_wait: got no job_done, required one within 20000 cycles");
    end
  endtask

  task automatic test_reset();
    rst = 0;
    #3;
    checks++;
    if ({job_ready, busy, wea_ext, s_ready, command_we0, command_we1, m_valid, job_done, timeout_err} !== 9'd0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 0", {job_ready, busy, wea_ext, s_ready, command_we0, command_we1, m_valid, job_done, timeout_err});
    end
    checks++;
    if ({address_ext, command_in, dina_ext, m_data} !== '0) begin
      errors++;
      $display("FAIL reset_buses: got addr %0h cmd %0h dina %0h mdata %0h required 0", address_ext, command_in, dina_ext, m_data);
    end
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    checks++;
    if (job_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_job_ready: got %b required 1", job_ready);
    end
  endtask

  task automatic test_add_job();
    run_job(5'd22, 10'd0, 10'd8, 10'd16, 10'd0, 11'd8, 10'd16, 11'd4, 0);
    checks++;
    if (wa_q.size() != 8) begin
      errors++;
      $display("FAIL add_wea_count: got %0d required 8", wa_q.size());
    end
    for (int k = 0; k < 8 && k < wa_q.size(); k++) begin
      checks++;
      if (wa_q[k] !== 10'(k) || wd_q[k] !== 64'(k + 1)) begin
        errors++;
        $display("FAIL add_write[%0d]: got addr %0d data %0h required addr %0d data %0h", k, wa_q[k], wd_q[k], k, k + 1);
      end
    end
    checks++;
    if (cmd_q.size() != 3) begin
      errors++;
      $display("FAIL add_cmd_count: got %0d required 3", cmd_q.size());
    end else begin
      checks++;
      if (cmd_q[0] !== {10'd0, 10'd0, 10'd16, 5'd0} || cmd_q[2] !== {10'd0, 10'd0, 10'd16, 5'd0}) begin
        errors++;
        $display("FAIL add_cfg_cmd: got %h / %h required %h", cmd_q[0], cmd_q[2], {10'd0, 10'd0, 10'd16, 5'd0});
      end
      checks++;
      if (cmd_q[1] !== {10'd16, 10'd8, 10'd0, 5'd22}) begin
        errors++;
        $display("FAIL add_ins_cmd: got %h required %h", cmd_q[1], {10'd16, 10'd8, 10'd0, 5'd22});
      end
    end
    checks++;
    if (md_q.size() != 4) begin
      errors++;
      $display("FAIL add_beats: got %0d required 4", md_q.size());
    end
    for (int k = 0; k < 4 && k < md_q.size(); k++) begin
      checks++;
      if (md_q[k] !== 64'hD0000 + 64'(k)) begin
        errors++;
        $display("FAIL add_mdata[%0d]: got %h required %h", k, md_q[k], 64'hD0000 + 64'(k));
      end
    end
    checks++;
    if (done_cnt != 1 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL add_done: got done %0d terr %b required done 1 terr 0", done_cnt, timeout_err);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    run_job(5'd24, 10'd1, 10'd2, 10'd3, 10'd0, 11'd0, 10'd0, 11'd1024, 1);
    checks++;
    if (md_q.size() != 1024) begin
      errors++;
      $display("FAIL bp_beats: got %0d required 1024", md_q.size());
    end
    bad = -1;
    for (int k = 0; k < md_q.size(); k++)
      if (bad < 0 && md_q[k] !== 64'hD0000 + 64'(k % 1024)) bad = k;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL bp_order: beat %0d got %h required %h", bad, md_q[bad], 64'hD0000 + 64'(bad % 1024));
    end
    checks++;
    if (stall_viol != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL bp_stall: got %0d unstable stalls, done %0d required 0 and 1", stall_viol, done_cnt);
    end
  endtask

  task automatic test_timeout();
    auto_done = 0;
    run_job(5'd23, 10'd0, 10'd0, 10'd0, 10'd0, 11'd0, 10'd0, 11'd4, 0);
    auto_done = 1;
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL to_flag: got %b required 1", timeout_err);
    end
    checks++;
    if (busy_cnt != 20) begin
      errors++;
      $display("FAIL to_cycles: got %0d busy cycles required 20", busy_cnt);
    end
    checks++;
    if (cmd_q.size() != 3 || mv_cnt != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL to_path: got cmds %0d m_valid %0d done %0d required 3 0 1", cmd_q.size(), mv_cnt, done_cnt);
    end
  endtask

  task automatic test_zero_counts();
    run_job(5'd18, 10'd5, 10'd6, 10'd7, 10'd9, 11'd0, 10'd3, 11'd0, 0);
    checks++;
    if (busy_cnt != 10) begin
      errors++;
      $display("FAIL zero_cycles: got %0d busy cycles required 10", busy_cnt);
    end
    checks++;
    if (wa_q.size() != 0 || mv_cnt != 0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL zero_io: got wea %0d m_valid %0d terr %b required 0 0 0", wa_q.size(), mv_cnt, timeout_err);
    end
    checks++;
    if (cmd_q.size() != 3 || cmd_q[0] !== {10'd9, 10'd0, 10'd3, 5'd0}) begin
      errors++;
      $display("FAIL zero_cmd: got %0d cmds, first %h required 3, %h", cmd_q.size(), cmd_q[0], {10'd9, 10'd0, 10'd3, 5'd0});
    end
  endtask

  task automatic test_stale_done();
    force_done = 1;
    run_job(5'd22, 10'd0, 10'd0, 10'd0, 10'd0, 11'd0, 10'd0, 11'd0, 0);
    force_done = 0;
    checks++;
    if (busy_cnt != 6 || done_cnt != 1) begin
      errors++;
      $display("FAIL stale_done: got %0d busy cycles done %0d required 6 and 1", busy_cnt, done_cnt);
    end
  endtask

  task automatic test_reset_mid_load();
    start_job(5'd22, 10'd0, 10'd8, 10'd16, 10'd0, 11'd8, 10'd16, 11'd4);
    @(posedge clk); #1;
    s_valid = 1;
    for (int k = 0; k < 3; k++) begin
      s_data = 64'(k + 1);
      @(posedge clk); #1;
    end
    rst = 0;
    #1;
    checks++;
    if ({busy, wea_ext, s_ready, command_we0, job_done, m_valid, job_ready, address_ext, dina_ext} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: busy %b wea %b s_ready %b we0 %b addr %0h required all 0", busy, wea_ext, s_ready, command_we0, address_ext);
    end
    checks++;
    if (wa_q.size() != 3 || done_cnt != 0) begin
      errors++;
      $display("FAIL midrst_writes: got %0d writes done %0d required 3 and 0", wa_q.size(), done_cnt);
    end
    s_valid = 0;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    test_add_job();
  endtask

  initial begin
    test_reset();
    test_add_job();
    test_backpressure();
    test_timeout();
    test_zero_counts();
    test_stale_done();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/compute_core_host_seq.md
# compute_core_host_seq

Host-side sequencer that drives the command/data port of the compute core: it stages an operand block into core BRAM, issues one instruction, waits for the core's completion flag, then streams a result block back out. It sits between a streaming host interface (job descriptor plus valid/ready data streams) and the core's `address_ext`/`dina_ext`/`wea_ext`/`command_in`/`command_we0`/`doutb_ext`/`done_ins_computation` pins. It is the initiator end of the protocol the core implements as responder.

## Interface

**Parameters**

- `DW`, default 64: data word width, equal to the core BRAM width.
- `AW`, default 10: BRAM address width, 1024 words.
- `TIMEOUT_CYC`, default 1048576: maximum number of WAIT cycles before the job aborts.
- `DELAY_BRAM`, default 1: `doutb_ext` latency after `address_ext`. The only supported value is 1.

**Ports**

- `clk`, in, 1: the single clock.
- `rst`, in, 1: asynchronous, active-low reset. 0 resets the block.
- `job_valid`, in, 1: job descriptor valid.
- `job_ready`, out, 1: high only in IDLE.
- `job_ins`, in, 5: instruction code, for example 18 TRNG, 22 add, 23 sub, 24 mul.
- `job_op1`, `job_op2`, `job_op3`, in, 10 each: instruction operands.
- `job_ld_base`, in, 10: BRAM base address for the load phase.
- `job_ld_cnt`, in, 11: number of words to load, 0 to 1024. Values above 1024 saturate to 1024.
- `job_rd_base`, in, 10: BRAM base address for readback.
- `job_rd_cnt`, in, 11: number of words to read back, 0 to 1024. Values above 1024 saturate to 1024.
- `s_data`, in, DW; `s_valid`, in, 1; `s_ready`, out, 1: load stream.
- `m_data`, out, DW; `m_valid`, out, 1; `m_ready`, in, 1: readback stream.
- `address_ext`, out, AW; `dina_ext`, out, DW; `wea_ext`, out, 1: core BRAM port.
- `command_in`, out, 35; `command_we0`, out, 1; `command_we1`, out, 1: core command port.
- `doutb_ext`, in, DW; `done_ins_computation`, in, 1: core outputs.
- `busy`, out, 1: high whenever the state is not IDLE.
- `job_done`, out, 1: one-cycle pulse at job end.
- `timeout_err`, out, 1: sticky error flag, cleared on the next job accept.

## Operation

- **Command word format:** `{OP3[34:25], OP2[24:15], OP1[14:5], INS[4:0]}`.
- **`command_we1`:** tied to 0.
- **IDLE:**
  - A job is accepted on `job_valid & job_ready`.
  - All descriptor fields are captured at acceptance; the counts are saturated at capture.
- **CFG_LD (1 cycle):**
  - `command_we0=1`, `command_in={job_ld_base,10'd0,job_rd_base,5'd0}`.
  - INS=0 keeps the core idle, so the core adds OP3 to `address_ext` for writes and OP1 to `address_ext` for reads.
- **LOAD:**
  - `s_ready=1`.
  - Each cycle with `s_valid` high: `wea_ext=1`, `address_ext` = load index i (0-based), `dina_ext=s_data`, then i increments.
  - When i reaches `ld_cnt`, go to CMD. If `ld_cnt=0`, LOAD is skipped.
- **CMD (1 cycle):**
  - `command_we0=1`, `command_in={op3,op2,op1,ins}`.
- **WAIT:**
  - The first WAIT cycle is a guard cycle in which `done_ins_computation` is ignored.
  - From the second WAIT cycle on, `done_ins_computation=1` moves the FSM to CFG_RD.
  - A cycle counter increments every WAIT cycle. If it reaches `TIMEOUT_CYC`, set `timeout_err`, skip READ, and go to CFG_RD, then DONE.
- **CFG_RD (1 cycle):**
  - Same command word as CFG_LD.
  - This returns the core to INS=0, which releases the BRAM to the external port.
- **READ:**
  - A 2-entry output FIFO feeds `m_*`.
  - A read is issued (`address_ext` = read index j, then j increments) only when FIFO occupancy plus in-flight reads is less than 2.
  - `doutb_ext` is captured into the FIFO one cycle after issue.
  - The FSM leaves READ when j equals `rd_cnt`, no read is in flight, and the FIFO is empty. If `rd_cnt=0`, READ is skipped.
- **DONE (1 cycle):** `job_done=1`, then return to IDLE.
- **Port defaults:** in every state other than those listed above, `wea_ext=0`, `command_we0=0`, `s_ready=0`, and `address_ext=0`.
- **Address wrap:** indices i and j are 10-bit. A count of 1024 wraps the index to 0 at termination, so termination is tested on an 11-bit counter. Physical addresses wrap modulo 1024 inside the core.

## Timing

- **Reset values:** all outputs 0, state IDLE, FIFO empty, counters 0. Because reset is asynchronous, asserting it mid-job aborts the job immediately, with no `job_done` and no command write. The core's own command register is not cleared by this block.
- **Job acceptance to load:** accept at edge T, CFG_LD during cycle T+1, first load write possible in cycle T+2.
- **Load throughput:** 1 word per cycle while `s_valid` stays high.
- **Command to WAIT:** CMD in cycle C, WAIT starts at C+1, done is first sampled at C+2.
- **Read latency:** a read issued in cycle R is captured at the end of R+1 and appears on `m_valid` in R+2.
- **Read throughput:** 1 word per cycle while `m_ready` stays high.
- **Backpressure:** `m_data` holds stable while `m_valid & ~m_ready`. No word is dropped or duplicated under any `m_ready` pattern.
- **Simultaneous events:** `done_ins_computation` asserted in the same cycle as a timeout is treated as done, and `timeout_err` is not set.

## Test plan

- **Add job:** `ins`=22, `ld_base`=0, `ld_cnt`=8, `op1`=0, `op2`=8, `op3`=16, `rd_base`=16, `rd_cnt`=4, data 1..8, core model returns done 5 cycles after CMD -> exactly 8 `wea_ext` pulses at addresses 0..7, commands in order `{0,0,16,0}`, `{16,8,0,22}`, `{0,0,16,0}`, 4 `m_data` beats, one `job_done`.
- **Randomized backpressure:** 50% random `m_ready` with `rd_cnt`=1024 -> 1024 words in address order 0..1023, `m_data` stable during stalls.
- **Timeout:** `TIMEOUT_CYC`=16 and done never asserted -> `timeout_err`=1 after 16 WAIT cycles, CFG_RD issued, no `m_valid`, `job_done` pulses.
- **Zero counts:** `ld_cnt`=0 and `rd_cnt`=0 -> job accept to `job_done` takes exactly CFG_LD + CMD + WAIT + CFG_RD + DONE cycles, with `wea_ext` never asserted.
- **Stale done:** `done_ins_computation` held high from before CMD -> ignored in the guard cycle, honored in the second WAIT cycle.
- **Reset mid-LOAD:** `rst`=0 after 3 load writes -> all outputs 0 immediately; a new job accepted after reset completes normally.
